// File: rtl/addsub_arbiter_if.sv
// Request/grant/result bundle between two requesting ports and the shared add/subtract unit.
interface addsub_arbiter_if #(
  parameter int unsigned DW = 8
);
  logic          req0;
  logic          op0;
  logic [DW-1:0] a0;
  logic [DW-1:0] b0;
  logic          req1;
  logic          op1;
  logic [DW-1:0] a1;
  logic [DW-1:0] b1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] result;
  logic          busy;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input  gnt0, gnt1, done0, done1, result, busy
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    output gnt0, gnt1, done0, done1, result, busy
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-port arbiter sharing one DW-bit add/subtract datapath; IDLE -> CALC -> DONE per operation,
// ties broken in favour of the port not served last.
module addsub_arbiter #(
  parameter int unsigned DW = 8
) (
  input  logic              clk,
  input  logic              reset,
  addsub_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_lp;
  logic          r_own;
  logic          r_op;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_result;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_done0;
  logic          r_done1;
  logic          r_busy;

  logic          w_any;
  logic          w_win;
  logic          w_op;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;

  // Winner select: lone requester wins, a tie goes to the port opposite the last-served one.
  assign w_any = bus.req0 | bus.req1;
  assign w_win = (bus.req0 & bus.req1) ? ~r_lp : bus.req1;
  assign w_op  = w_win ? bus.op1 : bus.op0;
  assign w_a   = w_win ? bus.a1  : bus.a0;
  assign w_b   = w_win ? bus.b1  : bus.b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_lp     <= 1'b1;
      r_own    <= 1'b0;
      r_op     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= CALC;
            r_own   <= w_win;
            r_lp    <= w_win;
            r_op    <= w_op;
            r_a     <= w_a;
            r_b     <= w_b;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_busy  <= 1'b1;
          end
        end
        CALC: begin
          r_state  <= DONE;
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_result <= r_op ? DW'(r_a + r_b) : DW'(r_a - r_b);
          r_done0  <= ~r_own;
          r_done1  <= r_own;
        end
        DONE: begin
          r_state <= IDLE;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0   = r_gnt0;
  assign bus.gnt1   = r_gnt1;
  assign bus.done0  = r_done0;
  assign bus.done1  = r_done1;
  assign bus.result = r_result;
  assign bus.busy   = r_busy;

endmodule
